// File: rtl/stream_cipher_mc_if.sv
// Handshake bundle for the multi-channel stream cipher: key load port,
// input beat (valid/ready) and registered output beat (valid/ready).
interface stream_cipher_mc_if #(
  parameter int LANES    = 4,
  parameter int CHANNELS = 4
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(LANES + 1);

  logic                 key_in;
  logic [CH_W-1:0]      key_ch;
  logic [7:0]           key;

  logic                 din_valid;
  logic                 din_ready;
  logic [CH_W-1:0]      din_ch;
  logic [8*LANES-1:0]   din;
  logic [CNT_W-1:0]     din_cnt;

  logic                 dout_valid;
  logic                 dout_ready;
  logic [8*LANES-1:0]   dout;
  logic [CH_W-1:0]      dout_ch;
  logic [CNT_W-1:0]     dout_cnt;
  logic                 dout_err;

  modport master (
    output key_in, key_ch, key,
    output din_valid, din_ch, din, din_cnt,
    input  din_ready,
    input  dout_valid, dout, dout_ch, dout_cnt, dout_err,
    output dout_ready
  );

  modport slave (
    input  key_in, key_ch, key,
    input  din_valid, din_ch, din, din_cnt,
    output din_ready,
    output dout_valid, dout, dout_ch, dout_cnt, dout_err,
    input  dout_ready
  );
endinterface

// File: rtl/stream_cipher_mc.sv
// Multi-channel, multi-lane counter-mode stream cipher with per-channel key
// contexts, partial beats and a single registered output stage.
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the AES S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(x, x);
    r  = sq;
    for (int k = 0; k < 6; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign y_o = affine(gf_inv(a_i));
endmodule

module stream_cipher_mc #(
  parameter int LANES    = 4,
  parameter int CHANNELS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_cipher_mc_if.slave  bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(LANES + 1);

  logic [7:0]          cb_q [CHANNELS];
  logic [7:0]          cb_d [CHANNELS];
  logic [CHANNELS-1:0] keyed_q, keyed_d;

  logic                vld_q, vld_d;
  logic [8*LANES-1:0]  dout_q, dout_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                din_ready;
  logic                accept;
  logic [CNT_W-1:0]    n;
  logic [7:0]          cb_sel;
  logic [7:0]          ctr [LANES];
  logic [7:0]          ks  [LANES];

  // Zero or over-range counts mean a full beat.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    if (c == '0 || int'(c) > LANES) return CNT_W'(LANES);
    return c;
  endfunction

  assign din_ready = (!vld_q || bus.dout_ready) && !bus.key_in;
  assign accept    = bus.din_valid && din_ready;
  assign n         = clamp_cnt(bus.din_cnt);
  assign cb_sel    = cb_q[bus.din_ch];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ctr[i] = cb_sel + 8'(i);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox u_sbox (
      .a_i (ctr[g]),
      .y_o (ks[g])
    );
  end

  always_comb begin
    cb_d    = cb_q;
    keyed_d = keyed_q;
    vld_d   = vld_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // key_in blocks din_ready, so a load and an accept are never concurrent.
    if (bus.key_in) begin
      cb_d[bus.key_ch]    = bus.key;
      keyed_d[bus.key_ch] = 1'b1;
    end else if (accept) begin
      cb_d[bus.din_ch] = cb_sel + 8'(n);
    end

    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        dout_d[8*i +: 8] = (i < int'(n)) ? (bus.din[8*i +: 8] ^ ks[i]) : 8'h00;
      end
      vld_d = 1'b1;
      ch_d  = bus.din_ch;
      cnt_d = n;
      err_d = !keyed_q[bus.din_ch];
    end else if (bus.dout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) cb_q[c] <= 8'h00;
      keyed_q <= '0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cb_q    <= cb_d;
      keyed_q <= keyed_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = vld_q;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = ch_q;
  assign bus.dout_cnt   = cnt_q;
  assign bus.dout_err   = err_q;
endmodule

// File: tb/tb_stream_cipher_mc.sv
// Bench for stream_cipher_mc: vector table, hand-written handshake/reset
// sequences and a randomized run against a per-channel reference model.
module tb_stream_cipher_mc;
  localparam int LANES    = 4;
  localparam int CHANNELS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_cipher_mc_if #(.LANES(LANES), .CHANNELS(CHANNELS)) bus ();

  stream_cipher_mc #(.LANES(LANES), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  // Reference model state
  int          cb_m    [CHANNELS];
  bit          keyed_m [CHANNELS];
  bit          m_vld;
  logic [31:0] m_dout;
  int          m_ch, m_cnt;
  bit          m_err;

  typedef struct {
    bit          do_key;
    int          ch;
    logic [7:0]  kval;
    logic [31:0] din;
    int          cnt;
    logic [31:0] exp_dout;
    int          exp_cnt;
    bit          exp_err;
  } vec_t;
  vec_t vecs [8];

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) r = r ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (r[k]) r = r ^ (16'h011b << (k - 8));
    return r[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input int x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic int clampn(input int cnt);
    return (cnt == 0 || cnt > LANES) ? LANES : cnt;
  endfunction

  function automatic logic [31:0] exp_ks(input logic [7:0] cb0, input int n, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (i < n) r[8*i +: 8] = d[8*i +: 8] ^ sbox_tab[(int'(cb0) + i) % 256];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      cb_m[c]    = 0;
      keyed_m[c] = 1'b0;
    end
    m_vld = 1'b0;
  endtask

  task automatic model_accept(input int ch, input logic [31:0] d, input int cnt);
    int n;
    n      = clampn(cnt);
    m_dout = exp_ks(8'(cb_m[ch]), n, d);
    m_cnt  = n;
    m_ch   = ch;
    m_err  = !keyed_m[ch];
    cb_m[ch] = (cb_m[ch] + n) % 256;
    m_vld  = 1'b1;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_vld"}, 64'(bus.dout_valid), 64'(m_vld));
    if (m_vld) begin
      chk({tag, "_dout"}, 64'(bus.dout), 64'(m_dout));
      chk({tag, "_ch"},   64'(bus.dout_ch), 64'(m_ch));
      chk({tag, "_cnt"},  64'(bus.dout_cnt), 64'(m_cnt));
      chk({tag, "_err"},  64'(bus.dout_err), 64'(m_err));
    end
  endtask

  // Called at posedge+1; returns at posedge+1
  task automatic do_key(input int ch, input logic [7:0] k);
    bus.key_in = 1'b1; bus.key_ch = 2'(ch); bus.key = k;
    bus.din_valid = 1'b0; bus.dout_ready = 1'b1;
    @(posedge clk);
    cb_m[ch] = int'(k); keyed_m[ch] = 1'b1; m_vld = 1'b0;
    #1 bus.key_in = 1'b0;
  endtask

  task automatic send(input int ch, input logic [31:0] d, input int cnt);
    bus.din_valid = 1'b1; bus.din_ch = 2'(ch); bus.din = d; bus.din_cnt = 3'(cnt);
    bus.dout_ready = 1'b1; bus.key_in = 1'b0;
    #1 chk("send_ready", 64'(bus.din_ready), 64'd1);
    @(posedge clk);
    model_accept(ch, d, cnt);
    #1 bus.din_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] hold;
    bit          rdy_m;

    for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_ref(x);

    vecs[0] = '{1'b1, 1, 8'h10, 32'h00000000, 4, exp_ks(8'h10, 4, 32'h00000000), 4, 1'b0};
    vecs[1] = '{1'b0, 1, 8'h00, 32'h01020304, 2, exp_ks(8'h14, 2, 32'h01020304), 2, 1'b0};
    vecs[2] = '{1'b1, 0, 8'hFE, 32'hAABBCCDD, 3, exp_ks(8'hFE, 3, 32'hAABBCCDD), 3, 1'b0};
    vecs[3] = '{1'b0, 0, 8'h00, 32'h11223344, 1, exp_ks(8'h01, 1, 32'h11223344), 1, 1'b0};
    vecs[4] = '{1'b0, 3, 8'h00, 32'h00000000, 0, exp_ks(8'h00, 4, 32'h00000000), 4, 1'b1};
    vecs[5] = '{1'b0, 3, 8'h00, 32'hFFFFFFFF, 5, exp_ks(8'h04, 4, 32'hFFFFFFFF), 4, 1'b1};
    vecs[6] = '{1'b1, 3, 8'hFF, 32'h00000000, 4, exp_ks(8'hFF, 4, 32'h00000000), 4, 1'b0};
    vecs[7] = '{1'b1, 1, 8'h10, 32'h5A5A5A5A, 4, exp_ks(8'h10, 4, 32'h5A5A5A5A), 4, 1'b0};

    bus.key_in = 1'b0; bus.key_ch = '0; bus.key = '0;
    bus.din_valid = 1'b0; bus.din_ch = '0; bus.din = '0; bus.din_cnt = '0;
    bus.dout_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld",  64'(bus.dout_valid), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_ch",   64'(bus.dout_ch), 64'd0);
    chk("rst_cnt",  64'(bus.dout_cnt), 64'd0);
    chk("rst_err",  64'(bus.dout_err), 64'd0);
    chk("rst_rdy",  64'(bus.din_ready), 64'd1);
    bus.key_in = 1'b1;
    #1 chk("rst_rdy_key", 64'(bus.din_ready), 64'd0);
    bus.key_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Vector table
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_key) do_key(vecs[v].ch, vecs[v].kval);
      send(vecs[v].ch, vecs[v].din, vecs[v].cnt);
      chk($sformatf("vec%0d_vld", v),  64'(bus.dout_valid), 64'd1);
      chk($sformatf("vec%0d_dout", v), 64'(bus.dout), 64'(vecs[v].exp_dout));
      chk($sformatf("vec%0d_ch", v),   64'(bus.dout_ch), 64'(vecs[v].ch));
      chk($sformatf("vec%0d_cnt", v),  64'(bus.dout_cnt), 64'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d_err", v),  64'(bus.dout_err), 64'(vecs[v].exp_err));
    end

    // Channel independence
    do_key(0, 8'h00);
    do_key(2, 8'h80);
    for (int k = 0; k < 8; k++) begin
      send((k % 2 == 0) ? 0 : 2, $urandom, $urandom_range(7));
      chk_out($sformatf("indep%0d", k));
    end

    // Backpressure with a pending beat
    do_key(1, 8'h33);
    bus.din_valid = 1'b1; bus.din_ch = 2'd1; bus.din = 32'hCAFEF00D; bus.din_cnt = 3'd4;
    bus.dout_ready = 1'b0;
    @(posedge clk);
    model_accept(1, 32'hCAFEF00D, 4);
    #1 chk_out("bp_first");
    hold = 32'h01234567;
    bus.din = hold;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_rdy%0d", k), 64'(bus.din_ready), 64'd0);
      chk_out($sformatf("bp_hold%0d", k));
      @(posedge clk); #1;
    end
    bus.key_in = 1'b1; bus.key_ch = 2'd2; bus.key = 8'h44;
    @(posedge clk);
    cb_m[2] = 8'h44; keyed_m[2] = 1'b1;
    #1 chk_out("bp_keyhold");
    bus.key_in = 1'b0;
    bus.dout_ready = 1'b1;
    #1 chk("bp_release_rdy", 64'(bus.din_ready), 64'd1);
    @(posedge clk);
    model_accept(1, hold, 4);
    #1 chk_out("bp_b2b");

    // Key load blocks data accept
    bus.key_in = 1'b1; bus.key_ch = 2'd3; bus.key = 8'h55;
    bus.din = 32'h89ABCDEF; bus.din_cnt = 3'd2;
    #1 chk("key_block_rdy", 64'(bus.din_ready), 64'd0);
    @(posedge clk);
    cb_m[3] = 8'h55; keyed_m[3] = 1'b1; m_vld = 1'b0;
    #1 chk_out("key_block");
    bus.key_in = 1'b0;
    @(posedge clk);
    model_accept(1, 32'h89ABCDEF, 2);
    #1 chk_out("after_key_block");
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b0;

    // Asynchronous reset with a pending beat
    chk("pre_rst_vld", 64'(bus.dout_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  64'(bus.dout_valid), 64'd0);
    chk("mid_rst_dout", 64'(bus.dout), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    send(1, 32'h00000000, 4);
    chk("post_rst_err",  64'(bus.dout_err), 64'd1);
    chk("post_rst_dout", 64'(bus.dout), 64'(exp_ks(8'h00, 4, 32'h00000000)));

    bus.dout_ready = 1'b1;
    @(posedge clk);
    m_vld = 1'b0;
    #1;

    // Randomized run against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.key_in     = ($urandom_range(7) == 0);
      bus.key_ch     = 2'($urandom_range(CHANNELS - 1));
      bus.key        = 8'($urandom);
      bus.din_valid  = ($urandom_range(3) != 0);
      bus.din_ch     = 2'($urandom_range(CHANNELS - 1));
      bus.din        = $urandom;
      bus.din_cnt    = 3'($urandom_range(7));
      bus.dout_ready = ($urandom_range(3) != 0);
      #1;
      rdy_m = (!m_vld || bus.dout_ready) && !bus.key_in;
      chk("rnd_rdy", 64'(bus.din_ready), 64'(rdy_m));
      @(posedge clk);
      if (bus.din_valid && rdy_m) model_accept(int'(bus.din_ch), bus.din, int'(bus.din_cnt));
      else if (bus.dout_ready) m_vld = 1'b0;
      if (bus.key_in) begin
        cb_m[bus.key_ch]    = int'(bus.key);
        keyed_m[bus.key_ch] = 1'b1;
      end
      #1 chk_out("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_cipher_mc.md
# stream_cipher_mc

Multi-channel, multi-lane successor to the byte-wide counter-mode stream cipher. Each beat carries up to LANES bytes. Every lane XORs its byte with the S-box of a per-channel 8-bit counter block, offset by the lane index. The block adds a valid/ready handshake on input and output, independent key contexts per channel, partial beats, and a registered output stage. It sits between the byte-stream source and the link layer, and uses the codebase's combinational 8-bit `sbox` module, with LANES instances.

## Interface
- LANES, 4: bytes per beat (1..16); lane i is bits [8i+7:8i].
- CHANNELS, 4: independent key/counter contexts (≥2); CH_W = clog2(CHANNELS), CNT_W = clog2(LANES+1) are derived.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  1  load `key` into channel `key_ch` this cycle.
- key_ch  in  CH_W  target channel of key load.
- key  in  8  initial counter block.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid && din_ready.
- din_ch  in  CH_W  channel of input beat.
- din  in  8*LANES  plaintext bytes.
- din_cnt  in  CNT_W  valid bytes in beat, low lanes first.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  output beat consumed when dout_valid && dout_ready.
- dout  out  8*LANES  ciphertext; lanes ≥ dout_cnt are 0.
- dout_ch  out  CH_W  channel of output beat.
- dout_cnt  out  CNT_W  valid bytes in output beat.
- dout_err  out  1  beat was processed on a channel never keyed since reset.

## Operation
- Per channel state: cb[c] (8 bit), keyed[c] (1 bit).
- Key load: on key_in, cb[key_ch] <= key and keyed[key_ch] <= 1. A reload of an already-keyed channel is allowed and restarts its stream.
- din_ready = (!dout_valid || dout_ready) && !key_in. A key load therefore never coincides with a data accept, and no same-cycle ordering rule is needed.
- Effective count n = din_cnt. If din_cnt is 0 or greater than LANES, n = LANES (clamp).
- On accept, for lane i < n: dout lane i <= din lane i XOR sbox((cb[din_ch] + i) mod 256). Lanes ≥ n <= 0.
- On accept, the counter and output fields update:
  - cb[din_ch] <= (cb[din_ch] + n) mod 256, with implicit 8-bit wrap.
  - dout_ch <= din_ch, dout_cnt <= n, dout_err <= !keyed[din_ch], dout_valid <= 1.
- Other channels' counters are untouched.
- Unkeyed channel: the beat is processed with the current cb, which is 0 after reset, and is flagged with dout_err.
- Output register: the beat holds stable while dout_valid && !dout_ready. It is cleared (dout_valid <= 0) when consumed with no new accept. Consume and accept in the same cycle replace it back to back.
- Key load while an output beat is pending does not alter the pending beat.

## Timing
- Reset (asynchronous, immediate):
  - dout_valid=0, dout=0, dout_ch=0, dout_cnt=0, dout_err=0.
  - All cb=0, all keyed=0.
  - din_ready then equals !key_in.
- Reset mid-operation drops any pending output beat and all key state.
- Latency: 1 cycle from accept edge to dout_valid high.
- Throughput: 1 beat/cycle sustained while dout_ready=1 and key_in=0.
- Backpressure: din_ready is combinational from dout_valid, dout_ready and key_in. No combinational path exists from din to dout.
- Counter wrap: 0xFF + 1 = 0x00, both across lanes within a beat and across beats.
- Key load takes effect on the next accepted beat of that channel, one cycle after key_in.

## Test plan
- Basic multi-lane, LANES=4:
  - Stimulus: key 0x10 to ch1, then beat ch1, din=0x00000000, cnt=4.
  - Response: dout = {sbox(13),sbox(12),sbox(11),sbox(10)}, dout_err=0.
  - Next beat on ch1 uses cb=0x14.
- Wrap and partial beat:
  - Stimulus: key 0xFE to ch0, then beat cnt=3, din=0xAABBCCDD.
  - Response: lanes 0..2 = DD^sbox(FE), CC^sbox(FF), BB^sbox(00); lane 3 = 0; dout_cnt=3.
  - Next beat uses cb=0x01.
- Channel independence:
  - Stimulus: interleave ch0 (key 0x00) and ch2 (key 0x80) beats.
  - Response: each channel's keystream advances only on its own beats, matching a per-channel reference model.
- Backpressure and key blocking:
  - Stimulus: hold dout_ready=0 with one beat pending.
  - Response: din_ready=0; dout and counters stable for 5 cycles.
  - Stimulus: assert key_in with dout_ready=1.
  - Response: din_ready=0 that cycle.
- Unkeyed and clamp:
  - Stimulus: beat on ch3 after reset, cnt=0.
  - Response: dout_err=1, dout_cnt=4, keystream sbox(00..03).
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while dout_valid=1.
  - Response: dout_valid=0 immediately.
  - Next beat on a previously keyed channel gives dout_err=1 and cb starting at 0.
